// File: rtl/line_window_buffer.sv
// line_window_buffer: builds a KSIZE x KSIZE pixel neighbourhood for every
// accepted raster pixel. It uses KSIZE-1 column-addressed line memories and a
// column shift register. It also tracks frame counters and flags framing errors.
module line_window_buffer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned KSIZE    = 3,
    parameter int unsigned MAX_COLS = 1024,
    parameter int unsigned COL_BITS = 10
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [COL_BITS-1:0]             cols_cfg,
    input  logic                            in_valid,
    input  logic                            in_sof,
    input  logic                            in_eol,
    input  logic [WIDTH-1:0]                in_data,
    output logic [KSIZE*KSIZE*WIDTH-1:0]    win_data,
    output logic                            win_valid,
    output logic [COL_BITS-1:0]             win_x,
    output logic [COL_BITS-1:0]             win_y,
    output logic                            cfg_err
);

    localparam int unsigned NLINES   = KSIZE - 1;
    localparam int unsigned HALF     = (KSIZE - 1) / 2;
    localparam int unsigned WIN_BITS = KSIZE * KSIZE * WIDTH;

    // Line memories: line k holds the row that is k+1 rows above the current one.
    logic [WIDTH-1:0]    line_mem [NLINES][MAX_COLS];

    logic [COL_BITS-1:0] col_q, col_d;
    logic [COL_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] cols_q, cols_d;
    logic                active_q, active_d;
    logic                err_q, err_d;
    logic                win_valid_q, win_valid_d;
    logic [COL_BITS-1:0] win_x_q, win_x_d;
    logic [COL_BITS-1:0] win_y_q, win_y_d;
    logic [WIN_BITS-1:0] win_q, win_d;

    logic [COL_BITS-1:0] col_cur, row_cur, cols_cur;
    logic                cfg_ok, pix_take, last_col;
    logic [WIDTH-1:0]    rd_line [NLINES];
    logic [WIDTH-1:0]    col_vec [KSIZE];

    // Counters, window shift, framing checks and next-state selection.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        cols_d      = cols_q;
        active_d    = active_q;
        err_d       = err_q;
        win_valid_d = 1'b0;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        win_d       = win_q;

        // A start-of-frame pixel overrides the running counters.
        col_cur  = in_sof ? '0 : col_q;
        row_cur  = in_sof ? '0 : row_q;
        cols_cur = in_sof ? cols_cfg : cols_q;
        cfg_ok   = (32'(cols_cfg) >= KSIZE) && (32'(cols_cfg) <= MAX_COLS);
        pix_take = in_valid && (in_sof ? cfg_ok : active_q);
        last_col = (col_cur == (cols_cur - COL_BITS'(1)));

        for (int unsigned k = 0; k < NLINES; k++) begin
            rd_line[k] = line_mem[k][col_cur];
        end
        // The oldest line goes on top, and the incoming pixel goes at the bottom.
        for (int unsigned r = 0; r < NLINES; r++) begin
            col_vec[r] = rd_line[NLINES-1-r];
        end
        col_vec[KSIZE-1] = in_data;

        if (in_valid && in_sof) begin
            cols_d   = cols_cfg;
            col_d    = '0;
            row_d    = '0;
            active_d = cfg_ok;
            err_d    = !cfg_ok;
        end

        if (pix_take) begin
            if (in_eol != last_col) begin
                err_d = 1'b1;
            end
            if (last_col || in_eol) begin
                col_d = '0;
                row_d = (row_cur != '1) ? row_cur + COL_BITS'(1) : row_cur;
            end else begin
                col_d = col_cur + COL_BITS'(1);
            end

            for (int unsigned r = 0; r < KSIZE; r++) begin
                for (int unsigned c = 0; c < KSIZE; c++) begin
                    if (c == KSIZE - 1) begin
                        win_d[(r*KSIZE+c)*WIDTH +: WIDTH] = col_vec[r];
                    end else begin
                        win_d[(r*KSIZE+c)*WIDTH +: WIDTH] = win_q[(r*KSIZE+c+1)*WIDTH +: WIDTH];
                    end
                end
            end

            if ((32'(col_cur) >= KSIZE - 1) && (32'(row_cur) >= KSIZE - 1)) begin
                win_valid_d = 1'b1;
                win_x_d     = col_cur - COL_BITS'(HALF);
                win_y_d     = row_cur - COL_BITS'(HALF);
            end
        end
    end

    // Line-memory update: push the column down one line and store the new pixel in line 0.
    always_ff @(posedge clk) begin
        if (reset_n && pix_take) begin
            line_mem[0][col_cur] <= in_data;
            for (int unsigned k = 1; k < NLINES; k++) begin
                line_mem[k][col_cur] <= rd_line[k-1];
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            cols_q      <= '0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            win_valid_q <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            win_q       <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            cols_q      <= cols_d;
            active_q    <= active_d;
            err_q       <= err_d;
            win_valid_q <= win_valid_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            win_q       <= win_d;
        end
    end

    assign win_data  = win_q;
    assign win_valid = win_valid_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;
    assign cfg_err   = err_q;

endmodule
